// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the debug/loader port and the data memory.
// slave: the arbiter; master: the surrounding pipeline, debug port and memory.
interface dmem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_we;
  logic          dbg_lock;
  logic [AW-1:0] dbg_adr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_datain;
  logic          mem_w;
  logic          mem_r;
  logic [DW-1:0] mem_dataout;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_adr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_adr, dbg_wdata,
    input  mem_dataout,
    output cpu_rdata, cpu_stall,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_adr, mem_datain, mem_w, mem_r
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_adr, cpu_wdata,
    output dbg_req, dbg_we, dbg_lock, dbg_adr, dbg_wdata,
    output mem_dataout,
    input  cpu_rdata, cpu_stall,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_adr, mem_datain, mem_w, mem_r
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage has priority, debug port gets bounded access
// through a starvation counter and a time-limited lock (burst) mode.
module dmem_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 16
) (
  input logic         clk,
  input logic         rst,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {S_CPU, S_DBG, S_LOCK} state_t;

  state_t        state;
  logic [SW-1:0] starve;
  logic [LW-1:0] lockcnt;
  logic          cpu_acc;
  logic          gnt;
  logic          stall;
  logic          lock_exit;
  logic          cpu_go;
  logic [AW-1:0] sel_adr;

  always_comb begin
    cpu_acc = bus.cpu_rd | bus.cpu_wr;
    gnt     = 1'b0;
    stall   = 1'b0;
    unique case (state)
      S_CPU:   gnt = bus.dbg_req & ~cpu_acc;
      S_DBG: begin
        gnt   = bus.dbg_req;
        stall = bus.dbg_req & cpu_acc;
      end
      S_LOCK: begin
        gnt   = bus.dbg_req;
        stall = cpu_acc;
      end
      default: ;
    endcase
    lock_exit = (gnt & ~bus.dbg_lock) | ~bus.dbg_req | (lockcnt == LW'(LOCK_MAX - 1));

    // An ungranted S_DBG cycle leaves the CPU unstalled, so its access must go through.
    cpu_go  = ~gnt & ~stall;
    sel_adr = gnt ? bus.dbg_adr : bus.cpu_adr;
  end

  assign bus.dbg_gnt    = gnt;
  assign bus.cpu_stall  = stall;
  assign bus.cpu_rdata  = bus.mem_dataout;
  assign bus.mem_adr    = sel_adr;
  assign bus.mem_datain = gnt ? bus.dbg_wdata : bus.cpu_wdata;
  assign bus.mem_w      = gnt ? bus.dbg_we  : (cpu_go & bus.cpu_wr);
  assign bus.mem_r      = gnt ? ~bus.dbg_we : (cpu_go & bus.cpu_rd & ~bus.cpu_wr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_CPU;
      starve         <= '0;
      lockcnt        <= '0;
      bus.dbg_rvalid <= 1'b0;
      bus.dbg_rdata  <= '0;
    end else begin
      bus.dbg_rvalid <= gnt & ~bus.dbg_we;
      if (gnt && !bus.dbg_we)
        bus.dbg_rdata <= bus.mem_dataout;

      unique case (state)
        S_CPU: begin
          if (!bus.dbg_req) begin
            starve <= '0;
          end else if (!cpu_acc) begin
            starve <= '0;
            if (bus.dbg_lock)
              state <= S_LOCK;
          end else begin
            starve <= starve + 1'b1;
            if (starve == SW'(STARVE_MAX - 1))
              state <= S_DBG;
          end
        end
        S_DBG: begin
          starve <= '0;
          state  <= (bus.dbg_req && bus.dbg_lock) ? S_LOCK : S_CPU;
        end
        S_LOCK: begin
          if (lock_exit) begin
            state   <= S_CPU;
            lockcnt <= '0;
          end else begin
            lockcnt <= lockcnt + 1'b1;
          end
        end
        default: state <= S_CPU;
      endcase
    end
  end
endmodule
